// File: rtl/pixel_row_readout_if.sv
// Pixel readout stream between the row controller and the frame readout.
// Handshake: the source raises VALID with DATA_OUT/COL/LAST stable and keeps
// them unchanged until a cycle in which VALID and READY are both high; that
// cycle is the transfer. VALID never drops without a transfer, and READY may
// toggle freely without affecting the source's outputs combinationally.
interface pixel_row_readout_if #(
    parameter int COUNTER_WIDTH = 8,
    parameter int COL_WIDTH     = 1
);
    logic [COUNTER_WIDTH-1:0] DATA_OUT;
    logic [COL_WIDTH-1:0]     COL;
    logic                     VALID;
    logic                     READY;
    logic                     LAST;

    modport master (output DATA_OUT, COL, VALID, LAST, input READY);
    modport slave  (input DATA_OUT, COL, VALID, LAST, output READY);
endinterface

// File: rtl/pixel_row_readout.sv
// Row conversion and readout controller: runs a shared ramp counter, latches
// each pixel's first comparator trip, then streams the row one pixel per
// transfer. dbg_state exposes the FSM state for observation.
module pixel_row_readout #(
    parameter int PIXEL_ARRAY_WIDTH = 2,
    parameter int COUNTER_WIDTH     = 8,
    parameter int EARLY_STOP        = 1,
    parameter int COL_WIDTH         = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         START,
    input  logic [PIXEL_ARRAY_WIDTH-1:0] CMP,
    output logic                         RAMP_EN,
    output logic [COUNTER_WIDTH-1:0]     COUNTER,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [1:0]                   dbg_state,
    pixel_row_readout_if.master          stream
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COL_WIDTH-1:0]     LAST_COL = COL_WIDTH'(PIXEL_ARRAY_WIDTH - 1);

    logic [1:0]                   state;
    logic [COUNTER_WIDTH-1:0]     counter;
    logic [PIXEL_ARRAY_WIDTH-1:0] captured;
    logic [COUNTER_WIDTH-1:0]     data [PIXEL_ARRAY_WIDTH];
    logic [COL_WIDTH-1:0]         col;
    logic                         done;

    logic [PIXEL_ARRAY_WIDTH-1:0] capture_now;
    logic [PIXEL_ARRAY_WIDTH-1:0] captured_next;
    logic                         saturate;
    logic                         conv_exit;
    logic                         transfer;
    logic                         last_word;

    // Capture and exit decisions for the current conversion cycle.
    always_comb begin
        capture_now   = CMP & ~captured;
        captured_next = captured | CMP;
        saturate      = (counter == CNT_MAX);
        conv_exit     = saturate || ((EARLY_STOP != 0) && (&captured_next));
        last_word     = (col == LAST_COL);
        transfer      = (state == ST_READOUT) && stream.READY;
    end

    // Control FSM: state, counter, capture flags, column index and DONE pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            counter  <= '0;
            captured <= '0;
            col      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state    <= ST_CONVERT;
                        counter  <= '0;
                        captured <= '0;
                        col      <= '0;
                    end
                end
                ST_CONVERT: begin
                    captured <= captured_next;
                    if (conv_exit) begin
                        // Counter holds its final value through readout.
                        state <= ST_READOUT;
                        if (saturate) begin
                            captured <= '1;
                        end
                    end else begin
                        counter <= counter + COUNTER_WIDTH'(1);
                    end
                end
                ST_READOUT: begin
                    if (transfer) begin
                        if (last_word) begin
                            state <= ST_IDLE;
                            col   <= '0;
                            done  <= 1'b1;
                        end else begin
                            col <= col + COL_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixel registers: cleared on START, first trip wins, saturate leftovers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
                data[i] <= '0;
            end
        end else if ((state == ST_IDLE) && START) begin
            for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
                data[i] <= '0;
            end
        end else if (state == ST_CONVERT) begin
            for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
                // At saturation the counter is all-ones, so loading it into an
                // uncaptured pixel is exactly the saturated value.
                if (capture_now[i] || (saturate && !captured[i])) begin
                    data[i] <= counter;
                end
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        RAMP_EN         = (state == ST_CONVERT);
        COUNTER         = counter;
        BUSY            = (state != ST_IDLE);
        DONE            = done;
        dbg_state       = state;
        stream.VALID    = (state == ST_READOUT);
        stream.COL      = col;
        stream.DATA_OUT = (state == ST_READOUT) ? data[col] : '0;
        stream.LAST     = (state == ST_READOUT) && last_word;
    end
endmodule
